uart_apb_ctrl: RTL and testbench

- APB3 slave front-end and sequencer for the UART core.
- Decodes each APB transfer into exactly one core command:
  - config write or read
  - TX data write
  - RX data read
- Holds the command strobe until the core's ready, captures read data and error, then completes the APB access with PREADY/PSLVERR.
- Sits between the system APB bus and the UART core's strobe interface.

---
 rtl/uart_apb_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_uart_apb_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_ctrl.sv
// rtl/uart_apb_ctrl.sv - APB3 slave front-end that turns each transfer into one UART core command (optional BUSY timeout: UART_APB_CTRL_TIMEOUT_EN)
module uart_apb_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int BAUD_ADDR      = 0,
    parameter int FRAME_ADDR     = 1,
    parameter int PARITY_ADDR    = 2,
    parameter int SBITS_ADDR     = 3,
    parameter int TX_ADDR        = 4,
    parameter int RX_ADDR        = 5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [ADDR_WIDTH-1:0] config_address,
    output logic [DATA_WIDTH-1:0] write_data_in,
    output logic                  config_write_detect,
    output logic                  config_read_detect,
    output logic                  TX_detect,
    output logic                  RX_detect,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  ready,
    input  logic                  error
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [ADDR_WIDTH-1:0] A_BAUD   = ADDR_WIDTH'(BAUD_ADDR);
    localparam logic [ADDR_WIDTH-1:0] A_FRAME  = ADDR_WIDTH'(FRAME_ADDR);
    localparam logic [ADDR_WIDTH-1:0] A_PARITY = ADDR_WIDTH'(PARITY_ADDR);
    localparam logic [ADDR_WIDTH-1:0] A_SBITS  = ADDR_WIDTH'(SBITS_ADDR);
    localparam logic [ADDR_WIDTH-1:0] A_TX     = ADDR_WIDTH'(TX_ADDR);
    localparam logic [ADDR_WIDTH-1:0] A_RX     = ADDR_WIDTH'(RX_ADDR);

    // Strobe vector bit order: {rx, tx, config read, config write}
    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    write_q, write_d;
    logic [3:0]              strb_q, strb_d;
    logic                    first_q, first_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic                    is_cfg;
    logic [3:0]              cmd;

`ifdef UART_APB_CTRL_TIMEOUT_EN
    localparam int                 CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]   TMO   = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]              cnt_q, cnt_d;
`endif

    // Decode the setup-phase address/direction into a one-hot command (zero = illegal)
    always_comb begin
        is_cfg = (PADDR == A_BAUD) || (PADDR == A_FRAME) ||
                 (PADDR == A_PARITY) || (PADDR == A_SBITS);
        cmd = 4'b0000;
        if (PWRITE) begin
            if (is_cfg)             cmd = 4'b0001;
            else if (PADDR == A_TX) cmd = 4'b0100;
        end else begin
            if (is_cfg)             cmd = 4'b0010;
            else if (PADDR == A_RX) cmd = 4'b1000;
        end
    end

    // Next-state and registered-output logic of the IDLE/BUSY/RESP sequencer
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        strb_d    = strb_q;
        first_d   = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
`ifdef UART_APB_CTRL_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    wdata_d = PWDATA;
                    write_d = PWRITE;
                    if (cmd != 4'b0000) begin
                        strb_d  = cmd;
                        first_d = 1'b1;
                        state_d = BUSY;
`ifdef UART_APB_CTRL_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        state_d   = RESP;
                    end
                end
            end
            BUSY: begin
`ifdef UART_APB_CTRL_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (!PSEL) begin
                    strb_d  = 4'b0000;
                    state_d = IDLE;
                end else if (!first_q && ready) begin
                    // first BUSY cycle is skipped so a stale registered ready cannot complete us
                    strb_d    = 4'b0000;
                    pready_d  = 1'b1;
                    pslverr_d = error;
                    prdata_d  = write_q ? '0 : read_data;
                    state_d   = RESP;
                end
`ifdef UART_APB_CTRL_TIMEOUT_EN
                else if (cnt_d == TMO) begin
                    strb_d    = 4'b0000;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = RESP;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            strb_q    <= 4'b0000;
            first_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef UART_APB_CTRL_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            strb_q    <= strb_d;
            first_q   <= first_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef UART_APB_CTRL_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign PREADY              = pready_q;
    assign PSLVERR             = pslverr_q;
    assign PRDATA              = prdata_q;
    assign config_address      = addr_q;
    assign write_data_in       = wdata_q;
    assign config_write_detect = strb_q[0];
    assign config_read_detect  = strb_q[1];
    assign TX_detect           = strb_q[2];
    assign RX_detect           = strb_q[3];

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// tb/tb_uart_apb_ctrl.sv - self-checking bench for uart_apb_ctrl with a behavioural UART core stand-in
module tb_uart_apb_ctrl;

`ifdef UART_APB_CTRL_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 4096;
`endif

    logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [7:0]  config_address;
    logic [31:0] write_data_in;
    logic        config_write_detect, config_read_detect, TX_detect, RX_detect;
    logic [31:0] read_data;
    logic        ready, error;
    logic [3:0]  strb;

    int n_checks = 0;
    int n_fail   = 0;

    // Core stand-in configuration, set by the stimulus
    int          core_delay = 1;
    logic        core_err   = 1'b0;
    logic [31:0] core_rx    = 32'h0;
    logic [31:0] core_regs [4];
    int          cm_cnt;
    bit          cm_done;

    // Expected configuration contents
    logic [31:0] ref_regs [4];

    uart_apb_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .config_address(config_address),
        .write_data_in(write_data_in), .config_write_detect(config_write_detect),
        .config_read_detect(config_read_detect), .TX_detect(TX_detect),
        .RX_detect(RX_detect), .read_data(read_data), .ready(ready), .error(error)
    );

    assign strb = {RX_detect, TX_detect, config_read_detect, config_write_detect};

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Core stand-in: answers a strobe after core_delay sampled strobe cycles with a one-cycle ready
    always @(posedge PCLK) begin
        if (!PRESETn) begin
            ready     <= 1'b0;
            error     <= 1'b0;
            read_data <= 32'h0;
            cm_cnt    <= 0;
            cm_done   <= 1'b0;
            for (int i = 0; i < 4; i++) core_regs[i] <= 32'h0;
        end else begin
            ready     <= 1'b0;
            error     <= 1'b0;
            read_data <= $urandom;
            if (strb == 4'b0000) begin
                cm_cnt  <= 0;
                cm_done <= 1'b0;
            end else if (!cm_done) begin
                if (cm_cnt == core_delay - 1) begin
                    ready   <= 1'b1;
                    error   <= core_err;
                    cm_done <= 1'b1;
                    if (config_write_detect) core_regs[config_address[1:0]] <= write_data_in;
                    if (config_read_detect)  read_data <= core_regs[config_address[1:0]];
                    if (RX_detect)           read_data <= core_rx;
                end else begin
                    cm_cnt <= cm_cnt + 1;
                end
            end
        end
    end

    function automatic logic [3:0] exp_strobe(input bit w, input int a);
        if (a < 4)  return w ? 4'b0001 : 4'b0010;
        if (a == 4) return w ? 4'b0100 : 4'b0000;
        if (a == 5) return w ? 4'b0000 : 4'b1000;
        return 4'b0000;
    endfunction

    // One APB transfer; reports latency (access cycles until PREADY), strobe activity and protocol faults
    task automatic xfer(input bit w, input int a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er,
                        output logic [3:0] sor, output int scyc, output int rcyc, output bit bad);
        logic [7:0] a8;
        a8 = a[7:0];
        lat = -1; rd = 32'h0; er = 1'b0; sor = 4'b0; scyc = 0; rcyc = -1; bad = 1'b0;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a8; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int k = 1; k <= 5000; k++) begin
            if (strb != 4'b0000) begin
                scyc++;
                sor |= strb;
                if (!$onehot(strb) || config_address !== a8 || write_data_in !== d) bad = 1'b1;
            end
            if (ready === 1'b1 && rcyc < 0) rcyc = k;
            if (PREADY === 1'b1) begin
                lat = k; rd = PRDATA; er = PSLVERR;
                break;
            end else if (PRDATA !== 32'h0 || PSLVERR !== 1'b0) begin
                bad = 1'b1;
            end
            @(posedge PCLK); #1;
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h0; PWDATA = 32'h0;
        for (int i = 0; i < 4; i++) ref_regs[i] = 32'h0;
        for (int c = 0; c < 8; c++) begin
            @(posedge PCLK); #1;
            if (c == 2) PRESETn = 1'b1;
            n_checks++;
            if ({PRDATA, PREADY, PSLVERR, config_address, write_data_in, strb} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: PRDATA=%h PREADY=%b PSLVERR=%b addr=%h wd=%h strb=%b, required all 0",
                         c, PRDATA, PREADY, PSLVERR, config_address, write_data_in, strb);
            end
        end
    endtask

    task automatic test_config();
        int lat, scyc, rcyc; logic [31:0] rd; logic er; logic [3:0] sor; bit bad;
        core_delay = 1; core_err = 1'b0;
        xfer(1'b1, 0, 32'd115200, lat, rd, er, sor, scyc, rcyc, bad);
        ref_regs[0] = 32'd115200;
        n_checks++; if (sor !== 4'b0001 || scyc !== 2) begin n_fail++;
            $display("FAIL cfg_wr_strobe: strobes=%b cycles=%0d, required 0001 for 2", sor, scyc); end
        n_checks++; if (lat !== 3 || er !== 1'b0 || bad) begin n_fail++;
            $display("FAIL cfg_wr_resp: lat=%0d err=%b bad=%b, required lat=3 err=0 bad=0", lat, er, bad); end
        xfer(1'b0, 0, 32'h0, lat, rd, er, sor, scyc, rcyc, bad);
        n_checks++; if (rd !== ref_regs[0] || er !== 1'b0 || lat !== 3 || sor !== 4'b0010 || bad) begin n_fail++;
            $display("FAIL cfg_rd: data=%0d err=%b lat=%0d strobes=%b bad=%b, required %0d 0 3 0010 0",
                     rd, er, lat, sor, bad, ref_regs[0]); end
    endtask

    task automatic test_tx();
        int lat, scyc, rcyc; logic [31:0] rd; logic er; logic [3:0] sor; bit bad;
        core_delay = 1000; core_err = 1'b0;
        xfer(1'b1, 4, 32'hA5, lat, rd, er, sor, scyc, rcyc, bad);
        n_checks++; if (sor !== 4'b0100 || scyc !== 1001 || bad) begin n_fail++;
            $display("FAIL tx_strobe: strobes=%b cycles=%0d bad=%b, required 0100 for 1001", sor, scyc, bad); end
        n_checks++; if (lat !== 1002 || lat !== rcyc + 1 || er !== 1'b0 || rd !== 32'h0) begin n_fail++;
            $display("FAIL tx_resp: lat=%0d ready_at=%0d err=%b data=%h, required lat=1002 one after ready, err=0 data=0",
                     lat, rcyc, er, rd); end
    endtask

    task automatic test_rx_err();
        int lat, scyc, rcyc; logic [31:0] rd; logic er; logic [3:0] sor; bit bad;
        core_delay = 3; core_err = 1'b1; core_rx = 32'h3C;
        xfer(1'b0, 5, 32'h0, lat, rd, er, sor, scyc, rcyc, bad);
        n_checks++; if (rd !== 32'h3C || er !== 1'b1 || sor !== 4'b1000 || lat !== 5) begin n_fail++;
            $display("FAIL rx_err: data=%h err=%b strobes=%b lat=%0d, required 3c 1 1000 5", rd, er, sor, lat); end
        core_err = 1'b0;
    endtask

    task automatic test_illegal();
        int lat, scyc, rcyc; logic [31:0] rd; logic er; logic [3:0] sor; bit bad;
        bit ws [3] = '{1'b1, 1'b0, 1'b0};
        int as [3] = '{5, 4, 9};
        core_delay = 1;
        for (int i = 0; i < 3; i++) begin
            xfer(ws[i], as[i], 32'hDEAD_BEEF, lat, rd, er, sor, scyc, rcyc, bad);
            n_checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || sor !== 4'b0000 || bad) begin n_fail++;
                $display("FAIL illegal_%0d: lat=%0d err=%b data=%h strobes=%b bad=%b, required 1 1 0 0000 0",
                         i, lat, er, rd, sor, bad); end
        end
    endtask

    // Random back-to-back transfers against the address-map model
    task automatic test_back_to_back();
        int lat, scyc, rcyc, a, el; logic [31:0] rd, d, erd; logic er, eer; logic [3:0] sor, es; bit bad, w;
        for (int n = 0; n < 40; n++) begin
            w = 1'(($urandom & 1));
            a = $urandom_range(0, 9);
            d = $urandom;
            core_delay = $urandom_range(1, 8);
            core_err   = 1'(($urandom_range(0, 3) == 0));
            core_rx    = {24'h0, 8'($urandom)};
            es = exp_strobe(w, a);
            if (es == 4'b0000) begin
                el = 1; eer = 1'b1; erd = 32'h0;
            end else begin
                el = core_delay + 2; eer = core_err;
                erd = w ? 32'h0 : (a < 4 ? ref_regs[a] : core_rx);
            end
            xfer(w, a, d, lat, rd, er, sor, scyc, rcyc, bad);
            if (w && a < 4) ref_regs[a] = d;
            n_checks++; if (lat !== el || rd !== erd || er !== eer || sor !== es || bad) begin n_fail++;
                $display("FAIL b2b_%0d w=%b a=%0d: lat=%0d data=%h err=%b strobes=%b bad=%b, required %0d %h %b %b 0",
                         n, w, a, lat, rd, er, sor, bad, el, erd, eer, es); end
            n_checks++; if (es != 4'b0000 && (scyc !== core_delay + 1 || lat !== rcyc + 1)) begin n_fail++;
                $display("FAIL b2b_timing_%0d: strobe_cycles=%0d ready_at=%0d lat=%0d, required %0d and lat=ready+1",
                         n, scyc, rcyc, lat, core_delay + 1); end
        end
    endtask

    task automatic test_abort_psel();
        int seen;
        core_delay = 1000;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd4; PWDATA = 32'h55;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        n_checks++; if (strb !== 4'b0000) begin n_fail++;
            $display("FAIL abort_psel_strobe: strb=%b, required 0000", strb); end
        seen = 0;
        repeat (4) begin
            @(posedge PCLK); #1;
            if (PREADY !== 1'b0 || strb !== 4'b0000) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++;
            $display("FAIL abort_psel_quiet: %0d cycles with PREADY or strobe, required 0", seen); end
    endtask

    task automatic test_abort_reset();
        core_delay = 1000;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'd4; PWDATA = 32'hA5;
        @(posedge PCLK); #1; PENABLE = 1'b1;
        repeat (5) @(posedge PCLK);
        #1;
        n_checks++; if (TX_detect !== 1'b1) begin n_fail++;
            $display("FAIL abort_rst_pre: TX_detect=%b, required 1", TX_detect); end
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        n_checks++; if ({PRDATA, PREADY, PSLVERR, config_address, write_data_in, strb} !== '0) begin n_fail++;
            $display("FAIL abort_rst_drop: strb=%b PREADY=%b addr=%h wd=%h, required all 0",
                     strb, PREADY, config_address, write_data_in); end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        for (int i = 0; i < 4; i++) ref_regs[i] = 32'h0;
        @(posedge PCLK); #1;
    endtask

`ifdef UART_APB_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int lat, scyc, rcyc; logic [31:0] rd; logic er; logic [3:0] sor; bit bad;
        core_delay = 100000;
        xfer(1'b0, 2, 32'h0, lat, rd, er, sor, scyc, rcyc, bad);
        n_checks++; if (lat !== TMO + 1 || er !== 1'b1 || rd !== 32'h0 || scyc !== TMO || sor !== 4'b0010) begin n_fail++;
            $display("FAIL timeout: lat=%0d err=%b data=%h strobe_cycles=%0d strobes=%b, required %0d 1 0 %0d 0010",
                     lat, er, rd, scyc, sor, TMO + 1, TMO); end
    endtask
`endif

    initial begin
        test_reset();
        test_config();
        test_tx();
        test_rx_err();
        test_illegal();
        test_back_to_back();
        test_abort_psel();
        test_abort_reset();
`ifdef UART_APB_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        test_config();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
